// File: rtl/vga_sync_gen.sv
// VGA sync/visible/strobe decode of column/row with an enable-gated delay pipe.
// Define VGA_SYNC_GEN_FRAME_COUNT_EN to build the frame_count register.
module vga_sync_gen #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int H_WHOLE_LINE  = 800,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int V_WHOLE_FRAME = 525,
  parameter bit H_SYNC_POL    = 1'b0,
  parameter bit V_SYNC_POL    = 1'b0,
  parameter int PIPE_DELAY    = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [$clog2(H_WHOLE_LINE)-1:0]  column,
  input  logic [$clog2(V_WHOLE_FRAME)-1:0] row,
  output logic                             vga_hsync,
  output logic                             vga_vsync,
  output logic                             visible,
  output logic                             line_start,
  output logic                             frame_start,
  output logic [15:0]                      frame_count
);

  localparam int CW = $clog2(H_WHOLE_LINE);
  localparam int RW = $clog2(V_WHOLE_FRAME);

  localparam int H_SB = H_VISIBLE + H_FRONT_PORCH;
  localparam int H_SE = H_SB + H_SYNC_PULSE;
  localparam int H_LM = H_SE + H_BACK_PORCH;
  localparam int V_SB = V_VISIBLE + V_FRONT_PORCH;
  localparam int V_SE = V_SB + V_SYNC_PULSE;
  localparam int V_LM = V_SE + V_BACK_PORCH;

  // One extra bit so a bound equal to 2**CW does not wrap to zero.
  localparam logic [CW:0] H_VIS_END  = H_VISIBLE[CW:0];
  localparam logic [CW:0] H_SYNC_BEG = H_SB[CW:0];
  localparam logic [CW:0] H_SYNC_END = H_SE[CW:0];
  localparam logic [CW:0] H_LIMIT    = H_LM[CW:0];
  localparam logic [RW:0] V_VIS_END  = V_VISIBLE[RW:0];
  localparam logic [RW:0] V_SYNC_BEG = V_SB[RW:0];
  localparam logic [RW:0] V_SYNC_END = V_SE[RW:0];
  localparam logic [RW:0] V_LIMIT    = V_LM[RW:0];

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } stage_t;

  logic [CW:0] col_x;
  logic [RW:0] row_x;
  logic        col_in;
  logic        row_in;
  stage_t      s0;
  stage_t      last;
  stage_t      pipe_q [PIPE_DELAY];
  stage_t      pipe_d [PIPE_DELAY];

  assign col_x = {1'b0, column};
  assign row_x = {1'b0, row};

  always_comb begin
    col_in = col_x < H_LIMIT;
    row_in = row_x < V_LIMIT;
    s0     = '0;
    s0.vis = (col_x < H_VIS_END) & (row_x < V_VIS_END);
    s0.hs  = col_in & (col_x >= H_SYNC_BEG) & (col_x < H_SYNC_END);
    s0.vs  = row_in & (row_x >= V_SYNC_BEG) & (row_x < V_SYNC_END);
    s0.ls  = (column == '0);
    s0.fs  = (column == '0) & (row == '0);
  end

  always_comb begin
    for (int i = 0; i < PIPE_DELAY; i++) begin
      pipe_d[i] = pipe_q[i];
    end
    if (enable) begin
      pipe_d[0] = s0;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign last = pipe_q[PIPE_DELAY-1];

  // Strobes are gated so a stalled final stage cannot repeat a pulse.
  assign vga_hsync   = last.hs ^ ~H_SYNC_POL;
  assign vga_vsync   = last.vs ^ ~V_SYNC_POL;
  assign visible     = last.vis;
  assign line_start  = last.ls & enable;
  assign frame_start = last.fs & enable;

`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
  logic [15:0] frame_count_q;
  logic [15:0] frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: reset, latency, stall, sweep, polarity.
// Build with VGA_SYNC_GEN_FRAME_COUNT_EN to also exercise frame_count.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] column = '0;
  logic [9:0] row = '0;

  logic hs2, vs2, vis2, ls2, fs2;
  logic hs1, vs1, vis1, ls1, fs1;
  logic hs8, vs8, vis8, ls8, fs8;
  logic hsp, vsp, visp, lsp, fsp;
  logic [15:0] fc2, fc1, fc8, fcp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_d2 (
    .clk(clk), .reset(reset), .enable(enable),
    .column(column), .row(row),
    .vga_hsync(hs2), .vga_vsync(vs2), .visible(vis2),
    .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
  );

  vga_sync_gen #(.PIPE_DELAY(1)) u_d1 (
    .clk(clk), .reset(reset), .enable(enable),
    .column(column), .row(row),
    .vga_hsync(hs1), .vga_vsync(vs1), .visible(vis1),
    .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );

  vga_sync_gen #(.PIPE_DELAY(8)) u_d8 (
    .clk(clk), .reset(reset), .enable(enable),
    .column(column), .row(row),
    .vga_hsync(hs8), .vga_vsync(vs8), .visible(vis8),
    .line_start(ls8), .frame_start(fs8), .frame_count(fc8)
  );

  vga_sync_gen #(.H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) u_pl (
    .clk(clk), .reset(reset), .enable(enable),
    .column(column), .row(row),
    .vga_hsync(hsp), .vga_vsync(vsp), .visible(visp),
    .line_start(lsp), .frame_start(fsp), .frame_count(fcp)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive just after the edge, return at the following negedge.
  task automatic cycle(input logic rst, input logic en,
                       input int c, input int r);
    @(posedge clk);
    #1;
    reset  = rst;
    enable = en;
    column = c[9:0];
    row    = r[9:0];
    @(negedge clk);
  endtask

  int c, r, ac, ar;
  int h0c, h0r, h1c, h1r, h2c, h2r;
  int vis_n, hlo_n, hfirst, hlast, vlo_n, phi_n, pvhi_n;
  int ls_n, fs_n, vis_en_n;
  bit done;
  int lines [$];

  initial begin
    // Reset hold with a visible coordinate and enable high.
    for (int i = 0; i < 3; i++) cycle(1, 1, 123, 45);
    check("rst_hsync", hs2, 1);
    check("rst_vsync", vs2, 1);
    check("rst_visible", vis2, 0);
    check("rst_line_start", ls2, 0);
    check("rst_frame_start", fs2, 0);
    check("rst_frame_count", fc2, 0);
    check("rst_pol_hsync", hsp, 0);
    check("rst_pol_vsync", vsp, 0);
    check("rst_d8_visible", vis8, 0);

    // Refill after release: PIPE_DELAY enabled cycles of reset values.
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 1, 5, 5);
      if (k == 2) check("fill_d2_k2", vis2, 0);
      if (k == 3) check("fill_d2_k3", vis2, 1);
      if (k == 8) check("fill_d8_k8", vis8, 0);
      if (k == 9) check("fill_d8_k9", vis8, 1);
    end

    // Latency: one (0,0) sample, strobe emerges PIPE_DELAY edges later.
    cycle(0, 1, 0, 0);
    for (int j = 1; j <= 10; j++) begin
      cycle(0, 1, j, 0);
      check($sformatf("lat_d1_fs_%0d", j), fs1, (j == 1) ? 1 : 0);
      check($sformatf("lat_d2_fs_%0d", j), fs2, (j == 2) ? 1 : 0);
      check($sformatf("lat_d8_fs_%0d", j), fs8, (j == 8) ? 1 : 0);
      check($sformatf("lat_d2_ls_%0d", j), ls2, (j == 2) ? 1 : 0);
    end

    // Enable stall across the frame wrap: (524,790) .. (0,20).
    cycle(1, 1, 700, 300);
    cycle(1, 1, 700, 300);
    c = 790; r = 524; done = 0;
    ls_n = 0; fs_n = 0; vis_n = 0; vis_en_n = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) cycle(0, i[0], 700, 300);
      else cycle(0, i[0], c, r);
      ls_n     += int'(ls2);
      fs_n     += int'(fs2);
      vis_n    += int'(vis2);
      vis_en_n += int'(vis2 & enable);
      if (i[0] && !done) begin
        if (c == 20 && r == 0) done = 1;
        else begin
          c++;
          if (c == 800) begin
            c = 0;
            r = (r + 1) % 525;
          end
        end
      end
    end
    check("stall_frame_start", fs_n, 1);
    check("stall_line_start", ls_n, 1);
    check("stall_visible_all", vis_n, 42);
    check("stall_visible_en", vis_en_n, 21);

    // Sweep: rows 0,1, 478..524, 0,1 with the pixel counter running.
    cycle(1, 1, 100, 100);
    cycle(1, 1, 100, 100);
    lines = {0, 1};
    for (int k = 478; k <= 524; k++) lines.push_back(k);
    lines.push_back(0);
    lines.push_back(1);
    h0c = -1; h1c = -1; h2c = -1; h0r = -1; h1r = -1; h2r = -1;
    vis_n = 0; hlo_n = 0; hfirst = -1; hlast = -1;
    vlo_n = 0; phi_n = 0; pvhi_n = 0; ls_n = 0; fs_n = 0;
    for (int li = 0; li <= lines.size(); li++) begin
      for (int cc = 0; cc < 800; cc++) begin
        if (li == lines.size() && cc >= 2) break;
        h2c = h1c; h2r = h1r; h1c = h0c; h1r = h0r;
        if (li == lines.size()) begin
          h0c = -1; h0r = -1;
          cycle(0, 1, 100, 100);
        end else begin
          h0c = cc; h0r = lines[li];
          cycle(0, 1, cc, lines[li]);
        end
        ac = h2c; ar = h2r;
        if (ac >= 0) begin
          vis_n  += int'(vis2);
          vlo_n  += int'(!vs2);
          phi_n  += int'(hsp);
          pvhi_n += int'(vsp);
          ls_n   += int'(ls2);
          fs_n   += int'(fs2);
          if (!hs2) begin
            hlo_n++;
            if (hfirst < 0) hfirst = ac;
            hlast = ac;
          end
          if (ac == 799) begin
            check($sformatf("sw_vis_r%0d", ar), vis_n, (ar < 480) ? 640 : 0);
            check($sformatf("sw_hlo_r%0d", ar), hlo_n, 96);
            check($sformatf("sw_hbeg_r%0d", ar), hfirst, 656);
            check($sformatf("sw_hend_r%0d", ar), hlast, 751);
            check($sformatf("sw_vlo_r%0d", ar), vlo_n,
                  (ar == 490 || ar == 491) ? 800 : 0);
            check($sformatf("sw_pol_h_r%0d", ar), phi_n, 96);
            check($sformatf("sw_pol_v_r%0d", ar), pvhi_n,
                  (ar == 490 || ar == 491) ? 800 : 0);
            vis_n = 0; hlo_n = 0; hfirst = -1; hlast = -1;
            vlo_n = 0; phi_n = 0; pvhi_n = 0;
          end
        end
      end
    end
    check("sw_line_starts", ls_n, 51);
    check("sw_frame_starts", fs_n, 2);

`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
    check("fc_after_sweep", fc2, 2);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 100, 100);
    cycle(0, 1, 100, 100);
    check("fc_three", fc2, 3);
    force u_d2.frame_count_q = 16'hffff;
    #1;
    release u_d2.frame_count_q;
    cycle(0, 1, 100, 100);
    check("fc_preload", fc2, 65535);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 100, 100);
    cycle(0, 1, 100, 100);
    check("fc_wrap", fc2, 0);
`else
    check("fc_tied_d2", fc2, 0);
    check("fc_tied_d8", fc8, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Registered VGA timing decoder that sits directly downstream of the pixel address counter. It takes the free-running column/row pair and produces hsync, vsync, the visible-area flag and line/frame start strobes. All outputs pass through a programmable-depth delay pipeline, so they stay aligned with pixel data coming out of a framebuffer read path of matching latency.

## Interface

Parameters (defaults are 640x480@60):
- H_VISIBLE, 640, active pixels per line
- H_FRONT_PORCH, 16, columns
- H_SYNC_PULSE, 96, columns
- H_BACK_PORCH, 48, columns
- H_WHOLE_LINE, 800, sum of the four H values
- V_VISIBLE, 480, active lines
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- V_WHOLE_FRAME, 525, sum of the four V values
- H_SYNC_POL, 0, active level of vga_hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vga_vsync
- PIPE_DELAY, 2, delay stages, legal range 1..8

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high
- enable  input  1  pixel advance; same signal that drives the upstream counter
- column  input  $clog2(H_WHOLE_LINE)  current column
- row  input  $clog2(V_WHOLE_FRAME)  current row
- vga_hsync  output  1  horizontal sync at pin polarity
- vga_vsync  output  1  vertical sync at pin polarity
- visible  output  1  pixel lies in the active area
- line_start  output  1  one-cycle strobe at column 0
- frame_start  output  1  one-cycle strobe at column 0, row 0
- frame_count  output  16  frames output (see Configuration)

## Operation

- Stage-0 decode is combinational from column/row:
  - vis = (column < H_VISIBLE) & (row < V_VISIBLE)
  - hs_act = column in [H_VISIBLE+H_FRONT_PORCH, H_VISIBLE+H_FRONT_PORCH+H_SYNC_PULSE)
  - vs_act = row in [V_VISIBLE+V_FRONT_PORCH, V_VISIBLE+V_FRONT_PORCH+V_SYNC_PULSE)
  - ls = (column == 0); fs = ls & (row == 0)
- Comparisons are unsigned at input width. Range bounds are computed as localparams; no runtime arithmetic.
- Stage-0 values enter a shift pipeline of PIPE_DELAY register stages. Every stage loads only on cycles with enable=1; with enable=0 all stages hold.
- Polarity is applied at the final stage only:
  - vga_hsync = hs_act XOR ~H_SYNC_POL
  - vga_vsync = vs_act XOR ~V_SYNC_POL
- line_start and frame_start are the final-stage bits ANDed with enable. This guarantees exactly one strobe per line/frame even when enable stalls.
- Column/row values outside the whole-line/frame range decode as not visible and not in sync. No error is flagged.

## Timing

- Latency: outputs reflect the column/row presented PIPE_DELAY enabled cycles earlier.
- Reset clears every stage to inactive on the clock edge where reset=1. Output values while in reset:
  - vga_hsync = ~H_SYNC_POL, vga_vsync = ~V_SYNC_POL
  - visible = 0, line_start = 0, frame_start = 0, frame_count = 0
- After reset is released, outputs stay at reset values for the first PIPE_DELAY enabled cycles. They then track the inputs.
- Reset mid-frame: same behaviour, no partial sync pulse is extended, and the pipeline refills from the current inputs.
- Line wrap (column 799 to 0) and frame wrap (row 524 to 0) need no special handling; the strobes are derived from the decoded values.
- Simultaneous reset and enable: reset wins.

## Configuration

- Macro: VGA_SYNC_GEN_FRAME_COUNT_EN.
- Defined: frame_count is a 16-bit register, reset to 0, incremented on each cycle where the frame_start output is 1. It wraps 65535 to 0.
- Undefined: frame_count is tied to 0 and no counter logic is synthesized. The port list is identical in both builds.

## Test plan

- Reset hold: reset=1 for 3 cycles with arbitrary column/row, default polarity -> vga_hsync=1, vga_vsync=1, visible=0, strobes 0, frame_count=0.
- Full frame sweep, enable=1, PIPE_DELAY=2, driven by the real pixel address counter. Required response, in cycle counts after the aligned frame_start:
  - visible high for exactly 640 cycles per line on lines 0..479
  - vga_hsync low for columns 656..751
  - vga_vsync low for rows 490..491
  - exactly 525 line_start and 1 frame_start per 420000 cycles
- Latency check: force column=0, row=0 at cycle N -> frame_start=1 at cycle N+PIPE_DELAY; repeat with PIPE_DELAY=1 and 8.
- Enable stall: enable toggling 1/0 every cycle -> decoded outputs advance only on enabled cycles, and frame_start pulses exactly once per frame.
- Polarity: H_SYNC_POL=1, V_SYNC_POL=1 -> vga_hsync high only for columns 656..751, and idle/reset level is 0.
- Frame counter (macro defined): run 3 frames from reset -> frame_count reads 3. Preload the counter to 65535, then one frame_start -> 0. Macro undefined -> frame_count stays 0 throughout.
